// File: rtl/chunk_stream_sequencer.sv
// chunk_stream_sequencer
//   Moves one lattice chunk through three phases: load, compute and drain.
//   It also drives the mode and address side of the BRAM port mux that sits
//   directly downstream.
//   - LOAD   : the packed 9-direction AXI-Stream from DDR is written into the
//              direction BRAMs at DDR_addr. The write enable is the mux's
//              chunk_transfer_ready.
//   - COMPUTE: the solver owns the BRAMs. The block pulses lbm_start and then
//              waits for lbm_done.
//   - DRAIN  : the chunk is read back through a 2-entry skid buffer onto the
//              AXI-Stream master. cache_in is driven to 0, so the READ_FIRST
//              BRAM clears each cell as it is read.
//
// Ports
//   m00_axis_aclk / m00_axis_aresetn : clock, synchronous active-low reset
//   start, busy, chunk_done, load_err : control and status
//   s_axis_*                          : DDR -> BRAM load stream (slave)
//   m_axis_*                          : BRAM -> DDR drain stream (master)
//   chunk_transfer_ready, chunk_compute_ready, DDR_addr, cache_in, cache_out
//                                     : BRAM port mux interface
//   lbm_start / lbm_done              : solver handshake
//
// Beat packing on tdata, cache_in and cache_out, with the null direction in the LSBs:
//   {nw, w, sw, s, se, e, ne, n, null}
module chunk_stream_sequencer #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 12,
  parameter int CHUNK_CELLS = 4096
) (
  input  logic                m00_axis_aclk,
  input  logic                m00_axis_aresetn,
  input  logic                start,
  output logic                busy,
  output logic                chunk_done,
  output logic                load_err,
  input  logic [9*DATA_W-1:0] s_axis_tdata,
  input  logic                s_axis_tvalid,
  output logic                s_axis_tready,
  input  logic                s_axis_tlast,
  output logic [9*DATA_W-1:0] m_axis_tdata,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic                m_axis_tlast,
  output logic                chunk_transfer_ready,
  output logic                chunk_compute_ready,
  output logic [ADDR_W-1:0]   DDR_addr,
  output logic [9*DATA_W-1:0] cache_in,
  input  logic [9*DATA_W-1:0] cache_out,
  output logic                lbm_start,
  input  logic                lbm_done
);

  localparam int BEAT_W = 9 * DATA_W;
  // One extra bit, so a counter can hold CHUNK_CELLS itself without wrapping.
  localparam int CNT_W  = $clog2(CHUNK_CELLS) + 1;

  localparam logic [CNT_W-1:0] CELLS    = CNT_W'(CHUNK_CELLS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CHUNK_CELLS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_COMPUTE,
    S_DRAIN
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;

  logic [CNT_W-1:0]         r_load_cnt;   // beats accepted in LOAD
  logic [CNT_W-1:0]         r_issue_cnt;  // BRAM reads issued in DRAIN
  logic [CNT_W-1:0]         r_beat_cnt;   // beats accepted on m_axis
  logic                     r_load_err;
  logic                     r_lbm_start;

  // Read pipeline and skid buffer. Slot 0 is always the head.
  logic                     r_inflight;   // a read was issued last cycle
  logic [1:0]               r_occ;        // skid occupancy, 0..2
  logic [1:0][BEAT_W-1:0]   r_skid;

  logic                     w_s_hs;
  logic                     w_load_last;
  logic                     w_pop;
  logic                     w_drain_last;
  logic [2:0]               w_slots;
  logic [2:0]               w_slot_lim;
  logic                     w_issue;

  // --------------------------------------------------------------------------
  // Handshakes and read-issue throttle
  // --------------------------------------------------------------------------
  assign w_s_hs      = (r_state == S_LOAD) && s_axis_tvalid;
  assign w_load_last = w_s_hs && (r_load_cnt == LAST_IDX);

  assign m_axis_tvalid = (r_occ != 2'd0);
  assign m_axis_tdata  = r_skid[0];
  assign m_axis_tlast  = m_axis_tvalid && (r_beat_cnt == LAST_IDX);

  assign w_pop        = m_axis_tvalid && m_axis_tready;
  assign w_drain_last = w_pop && (r_beat_cnt == LAST_IDX);

  // A read may be issued only if the skid buffer has room for everything
  // already committed: (occ - pop + inflight) < 2. The pop is moved to the
  // right-hand side so that the arithmetic stays unsigned.
  assign w_slots    = {1'b0, r_occ} + {2'b00, r_inflight};
  assign w_slot_lim = 3'd2 + {2'b00, w_pop};
  assign w_issue    = (r_state == S_DRAIN) && (r_issue_cnt < CELLS) &&
                      (w_slots < w_slot_lim);

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (start)        w_state_nxt = S_LOAD;
      S_LOAD:    if (w_load_last)  w_state_nxt = S_COMPUTE;
      S_COMPUTE: if (lbm_done)     w_state_nxt = S_DRAIN;
      S_DRAIN:   if (w_drain_last) w_state_nxt = S_IDLE;
      default:                     w_state_nxt = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs and mux control
  // --------------------------------------------------------------------------
  always_comb begin
    busy                 = (r_state != S_IDLE);
    s_axis_tready        = (r_state == S_LOAD);
    chunk_compute_ready  = (r_state == S_COMPUTE);
    chunk_transfer_ready = 1'b0;
    DDR_addr             = '0;
    cache_in             = '0;
    case (r_state)
      S_LOAD: begin
        // The mux forces the write enable high whenever transfer_ready is
        // high. Gating transfer_ready with tvalid therefore restricts BRAM
        // writes to accepted beats.
        chunk_transfer_ready = s_axis_tvalid;
        DDR_addr             = ADDR_W'(r_load_cnt);
        cache_in             = s_axis_tdata;
      end
      S_DRAIN: begin
        // cache_in stays 0: the READ_FIRST port returns the old cell and
        // then clears it.
        chunk_transfer_ready = w_issue;
        DDR_addr             = ADDR_W'(r_issue_cnt);
      end
      default: ;
    endcase
  end

  assign chunk_done = w_drain_last;
  assign load_err   = r_load_err;
  assign lbm_start  = r_lbm_start;

  // --------------------------------------------------------------------------
  // Sequential state
  // --------------------------------------------------------------------------
  always_ff @(posedge m00_axis_aclk) begin
    if (!m00_axis_aresetn) begin
      r_state     <= S_IDLE;
      r_load_cnt  <= '0;
      r_issue_cnt <= '0;
      r_beat_cnt  <= '0;
      r_load_err  <= 1'b0;
      r_lbm_start <= 1'b0;
      r_inflight  <= 1'b0;
      r_occ       <= 2'd0;
      r_skid      <= '0;
    end else begin
      r_state     <= w_state_nxt;
      // The pulse lands in the first COMPUTE cycle.
      r_lbm_start <= w_load_last;

      if (r_state == S_IDLE) begin
        r_load_cnt  <= '0;
        r_issue_cnt <= '0;
        r_beat_cnt  <= '0;
      end else begin
        if (w_s_hs)  r_load_cnt  <= r_load_cnt + 1'b1;
        if (w_issue) r_issue_cnt <= r_issue_cnt + 1'b1;
        if (w_pop)   r_beat_cnt  <= r_beat_cnt + 1'b1;
      end

      // tlast is checked against the count but never ends LOAD early.
      if (w_s_hs && (s_axis_tlast != (r_load_cnt == LAST_IDX)))
        r_load_err <= 1'b1;

      r_inflight <= w_issue;

      // The throttle guarantees that occ <= 1 whenever a capture lands.
      // A capture without a pop therefore always has a free slot.
      case ({r_inflight, w_pop})
        2'b10: begin
          if (r_occ == 2'd0) r_skid[0] <= cache_out;
          else               r_skid[1] <= cache_out;
          r_occ <= r_occ + 2'd1;
        end
        2'b11: begin
          // occ is 1 here: the head leaves and the new beat takes its place.
          r_skid[0] <= cache_out;
        end
        2'b01: begin
          r_skid[0] <= r_skid[1];
          r_occ     <= r_occ - 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_chunk_stream_sequencer.sv
module tb_chunk_stream_sequencer;
  localparam int DW = 16;
  localparam int AW = 12;
  localparam int N  = 8;
  localparam int BW = 9 * DW;

  logic          clk = 1'b0;
  logic          aresetn;
  logic          start;
  logic          busy, chunk_done, load_err;
  logic [BW-1:0] s_axis_tdata;
  logic          s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [BW-1:0] m_axis_tdata;
  logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic          chunk_transfer_ready, chunk_compute_ready;
  logic [AW-1:0] DDR_addr;
  logic [BW-1:0] cache_in;
  logic [BW-1:0] cache_out;
  logic          lbm_start, lbm_done;

  int checks = 0;
  int fails  = 0;

  logic [BW-1:0] sb[$];
  logic [BW-1:0] mem [0:N-1];
  int            wr_cnt = 0;
  bit            rdy_pat [12] = '{1, 0, 0, 1, 0, 1, 1, 0, 0, 0, 1, 0};

  always #5 clk = ~clk;

  chunk_stream_sequencer #(.DATA_W(DW), .ADDR_W(AW), .CHUNK_CELLS(N)) dut (
    .m00_axis_aclk(clk), .m00_axis_aresetn(aresetn), .start(start),
    .busy(busy), .chunk_done(chunk_done), .load_err(load_err),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .chunk_transfer_ready(chunk_transfer_ready),
    .chunk_compute_ready(chunk_compute_ready),
    .DDR_addr(DDR_addr), .cache_in(cache_in), .cache_out(cache_out),
    .lbm_start(lbm_start), .lbm_done(lbm_done)
  );

  // BRAM model: READ_FIRST, 1-cycle latency, write enable tied to transfer_ready.
  always @(posedge clk) begin
    if (chunk_transfer_ready && DDR_addr < N) begin
      cache_out      <= mem[DDR_addr];
      mem[DDR_addr]  <= cache_in;
    end
    if (chunk_transfer_ready && s_axis_tready) wr_cnt <= wr_cnt + 1;
  end

  function automatic logic [BW-1:0] mk(input int i, input int salt);
    logic [BW-1:0] r;
    for (int d = 0; d < 9; d++) r[d*DW +: DW] = DW'(i * 32'h1111 + d * salt * 32'h10 + salt);
    return r;
  endfunction

  task automatic test_reset;
    aresetn = 1'b0; start = 0; s_axis_tvalid = 0; s_axis_tlast = 0; s_axis_tdata = '0;
    m_axis_tready = 1; lbm_done = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, chunk_done, load_err, s_axis_tready, m_axis_tvalid, m_axis_tlast,
         chunk_transfer_ready, chunk_compute_ready, lbm_start} !== 9'b0) begin
      fails++; $display("FAIL rst_flags got=%b exp=0", {busy, chunk_done, load_err, s_axis_tready,
        m_axis_tvalid, m_axis_tlast, chunk_transfer_ready, chunk_compute_ready, lbm_start});
    end
    checks++;
    if (DDR_addr !== '0 || cache_in !== '0 || m_axis_tdata !== '0) begin
      fails++; $display("FAIL rst_data addr=%h cache_in=%h tdata=%h exp=0", DDR_addr, cache_in, m_axis_tdata);
    end
    aresetn = 1'b1;
    @(negedge clk);
  endtask

  // Starts a chunk and loads N beats. Returns at the first COMPUTE negedge.
  task automatic load_chunk(input int salt, input bit stall, input int tlast_beat, input bit exp_err);
    int acc, cyc, wr0;
    bit ph;
    acc = 0; cyc = 0; ph = 0; wr0 = wr_cnt;
    start = 1; @(negedge clk); start = 0;
    while (acc < N && cyc < 100) begin
      s_axis_tvalid = !(stall && ph);
      s_axis_tdata  = mk(acc, salt);
      s_axis_tlast  = (acc == tlast_beat);
      #1;
      checks++;
      if (s_axis_tready !== 1'b1 || busy !== 1'b1 || lbm_start !== 1'b0 || chunk_compute_ready !== 1'b0) begin
        fails++; $display("FAIL load_ctrl tready=%b busy=%b lbm_start=%b ccr=%b exp=1,1,0,0",
          s_axis_tready, busy, lbm_start, chunk_compute_ready);
      end
      checks++;
      if (chunk_transfer_ready !== s_axis_tvalid) begin
        fails++; $display("FAIL load_ctr got=%b exp=%b", chunk_transfer_ready, s_axis_tvalid);
      end
      checks++;
      if (DDR_addr !== AW'(acc)) begin
        fails++; $display("FAIL load_addr got=%0d exp=%0d", DDR_addr, acc);
      end
      if (s_axis_tvalid) begin
        checks++;
        if (cache_in !== mk(acc, salt)) begin
          fails++; $display("FAIL load_cache_in got=%h exp=%h", cache_in, mk(acc, salt));
        end
        sb.push_back(mk(acc, salt));
        acc++;
      end
      ph = !ph; cyc++;
      @(negedge clk);
    end
    s_axis_tvalid = 0; s_axis_tlast = 0;
    checks++;
    if (acc != N) begin fails++; $display("FAIL load_timeout beats=%0d exp=%0d", acc, N); end
    checks++;
    if (lbm_start !== 1'b1 || chunk_compute_ready !== 1'b1 || chunk_transfer_ready !== 1'b0) begin
      fails++; $display("FAIL lbm_start_pulse start=%b ccr=%b ctr=%b exp=1,1,0", lbm_start, chunk_compute_ready, chunk_transfer_ready);
    end
    checks++;
    if (wr_cnt - wr0 != N) begin fails++; $display("FAIL load_writes got=%0d exp=%0d", wr_cnt - wr0, N); end
    checks++;
    if (load_err !== exp_err) begin fails++; $display("FAIL load_err got=%b exp=%b", load_err, exp_err); end
  endtask

  // Called at the lbm_start negedge. lbm_done follows after dly cycles (0 = same cycle).
  task automatic compute(input int dly);
    for (int k = 0; k < dly; k++) begin
      start = 1;  // must be ignored outside IDLE
      @(negedge clk);
      start = 0;
      checks++;
      if (lbm_start !== 1'b0 || chunk_compute_ready !== 1'b1) begin
        fails++; $display("FAIL compute_wait lbm_start=%b ccr=%b exp=0,1", lbm_start, chunk_compute_ready);
      end
    end
    lbm_done = 1; @(negedge clk); lbm_done = 0;
  endtask

  // Called at the first DRAIN negedge. abort_at >= 0 returns after that many beats.
  task automatic drain(input int mode, input int abort_at, input bit exp_err);
    int beats, cyc, issued, popped, first_pop, last_pop;
    bit prev_stall, pop;
    logic [BW-1:0] prev_d, exp_d;
    logic prev_l;
    beats = 0; cyc = 0; issued = 0; popped = 0; first_pop = -1; last_pop = -1;
    prev_stall = 0; prev_d = '0; prev_l = 0;
    while (beats < N && cyc < 300) begin
      if (abort_at >= 0 && beats == abort_at) break;
      m_axis_tready = (mode == 0) ? 1'b1 : rdy_pat[cyc % 12];
      #1;
      if (prev_stall) begin
        checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== prev_d || m_axis_tlast !== prev_l) begin
          fails++; $display("FAIL drain_hold v=%b d=%h l=%b exp=1 %h %b", m_axis_tvalid, m_axis_tdata, m_axis_tlast, prev_d, prev_l);
        end
      end
      checks++;
      if (chunk_compute_ready !== 1'b0 || busy !== 1'b1) begin
        fails++; $display("FAIL drain_mode ccr=%b busy=%b exp=0,1", chunk_compute_ready, busy);
      end
      checks++;
      if (issued - popped > 2) begin
        fails++; $display("FAIL drain_outstanding got=%0d exp<=2", issued - popped);
      end
      if (chunk_transfer_ready) begin
        checks++;
        if (DDR_addr !== AW'(issued) || cache_in !== '0 || issued >= N) begin
          fails++; $display("FAIL drain_issue addr=%0d cache_in=%h exp addr=%0d cache_in=0", DDR_addr, cache_in, issued);
        end
        issued++;
      end
      pop = m_axis_tvalid && m_axis_tready;
      checks++;
      if (chunk_done !== (pop && beats == N - 1)) begin
        fails++; $display("FAIL chunk_done got=%b exp=%b", chunk_done, pop && beats == N - 1);
      end
      if (pop) begin
        exp_d = (sb.size() > 0) ? sb.pop_front() : '0;
        checks++;
        if (m_axis_tdata !== exp_d) begin
          fails++; $display("FAIL drain_data beat=%0d got=%h exp=%h", beats, m_axis_tdata, exp_d);
        end
        checks++;
        if (m_axis_tlast !== (beats == N - 1)) begin
          fails++; $display("FAIL drain_tlast beat=%0d got=%b exp=%b", beats, m_axis_tlast, beats == N - 1);
        end
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc; beats++; popped++;
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_d = m_axis_tdata; prev_l = m_axis_tlast;
      cyc++;
      @(negedge clk);
    end
    if (abort_at < 0) begin
      checks++;
      if (beats != N) begin fails++; $display("FAIL drain_timeout beats=%0d exp=%0d", beats, N); end
      if (mode == 0) begin
        checks++;
        if (first_pop != 2 || last_pop - first_pop != N - 1) begin
          fails++; $display("FAIL drain_rate first=%0d span=%0d exp=2,%0d", first_pop, last_pop - first_pop, N - 1);
        end
      end
      checks++;
      if (busy !== 1'b0 || chunk_done !== 1'b0 || m_axis_tvalid !== 1'b0 || load_err !== exp_err) begin
        fails++; $display("FAIL drain_end busy=%b done=%b v=%b err=%b exp=0,0,0,%b", busy, chunk_done, m_axis_tvalid, load_err, exp_err);
      end
      checks++;
      if (sb.size() != 0) begin fails++; $display("FAIL drain_sb_left got=%0d exp=0", sb.size()); end
      for (int a = 0; a < N; a++) begin
        checks++;
        if (mem[a] !== '0) begin fails++; $display("FAIL bram_cleared addr=%0d got=%h exp=0", a, mem[a]); end
      end
    end
  endtask

  task automatic test_basic_chunk;       // load with tlast on 7, full-rate drain
    load_chunk(0, 0, 7, 0); compute(1); drain(0, -1, 0);
  endtask

  task automatic test_stalls;            // tvalid toggling, patterned tready, same-cycle lbm_done
    load_chunk(1, 1, 7, 0); compute(0); drain(1, -1, 0);
  endtask

  task automatic test_tlast_err;         // misplaced tlast: sticky error, load still runs N beats
    load_chunk(2, 0, 3, 1); compute(2); drain(1, -1, 1);
    repeat (3) @(negedge clk);
    checks++;
    if (load_err !== 1'b1) begin fails++; $display("FAIL load_err_sticky got=%b exp=1", load_err); end
  endtask

  task automatic test_reset_mid_drain;
    load_chunk(3, 0, 7, 1); compute(1); drain(0, 4, 1);
    aresetn = 0; m_axis_tready = 1;
    @(negedge clk);
    checks++;
    if ({busy, chunk_done, load_err, s_axis_tready, m_axis_tvalid, m_axis_tlast,
         chunk_transfer_ready, chunk_compute_ready, lbm_start} !== 9'b0) begin
      fails++; $display("FAIL abort_flags got=%b exp=0", {busy, chunk_done, load_err, s_axis_tready,
        m_axis_tvalid, m_axis_tlast, chunk_transfer_ready, chunk_compute_ready, lbm_start});
    end
    checks++;
    if (DDR_addr !== '0 || cache_in !== '0 || m_axis_tdata !== '0) begin
      fails++; $display("FAIL abort_data addr=%h cache_in=%h tdata=%h exp=0", DDR_addr, cache_in, m_axis_tdata);
    end
    aresetn = 1; sb.delete();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (m_axis_tvalid !== 1'b0 || busy !== 1'b0) begin
        fails++; $display("FAIL abort_quiet v=%b busy=%b exp=0,0", m_axis_tvalid, busy);
      end
    end
    load_chunk(4, 0, 7, 0); compute(1); drain(0, -1, 0);
  endtask

  initial begin
    test_reset;
    test_basic_chunk;
    test_stalls;
    test_tlast_err;
    test_reset_mid_drain;
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/chunk_stream_sequencer.md
Name: chunk_stream_sequencer

Overview:
- Sequences one lattice chunk through load -> compute -> drain, and owns the mode/address side of the BRAM port mux that sits directly downstream of it.
- Accepts a packed 9-direction AXI-Stream from the DDR side and writes it into the nine direction BRAMs at DDR_addr.
- Starts and waits for the LBM solver.
- Reads the chunk back out of BRAM onto an AXI-Stream master, with 1-cycle BRAM read latency and full-rate backpressure handling.

Parameters:
- DATA_W, 16: width of one direction value.
- ADDR_W, 12: BRAM address width.
- CHUNK_CELLS, 4096: cells per chunk; must be ≤ 2^ADDR_W.

Ports:
- m00_axis_aclk  in  1  clock
- m00_axis_aresetn  in  1  synchronous active-low reset
- start  in  1  pulse; begin a chunk when IDLE
- busy  out  1  high in any state except IDLE
- chunk_done  out  1  1-cycle pulse when the last drain beat is accepted
- load_err  out  1  sticky; s_axis_tlast misplaced; cleared only by reset
- s_axis_tdata  in  9*DATA_W  packed {nw,w,sw,s,se,e,ne,n,null}; null is the LSBs
- s_axis_tvalid  in  1
- s_axis_tready  out  1
- s_axis_tlast  in  1
- m_axis_tdata  out  9*DATA_W  same packing as s_axis_tdata
- m_axis_tvalid  out  1
- m_axis_tready  in  1
- m_axis_tlast  out  1
- chunk_transfer_ready  out  1  to mux; BRAM write enable is forced to 1 while this is high
- chunk_compute_ready  out  1  to mux; solver owns the BRAMs
- DDR_addr  out  ADDR_W  BRAM address in transfer mode
- cache_in  out  9*DATA_W  write data to the mux (nine cache_*_in fields)
- cache_out  in  9*DATA_W  BRAM read data from the mux (nine cache_*_out fields)
- lbm_start  out  1  1-cycle pulse on COMPUTE entry
- lbm_done  in  1  solver completion pulse

Behaviour:
- Reset (synchronous, m00_axis_aresetn=0 at a clock edge):
  - State goes to IDLE; all counters clear; skid buffer empties.
  - These outputs are 0: busy, chunk_done, load_err, s_axis_tready, m_axis_tvalid, m_axis_tlast, chunk_transfer_ready, chunk_compute_ready, lbm_start, DDR_addr, cache_in.
  - m_axis_tdata resets to 0.
  - Reset mid-operation abandons the chunk. No partial beats are emitted afterwards.
- States: IDLE, LOAD, COMPUTE, DRAIN.
- IDLE -> LOAD on start. start is ignored in every other state.
- LOAD:
  - s_axis_tready=1.
  - chunk_transfer_ready is combinationally equal to s_axis_tvalid, so the BRAM is written only on accepted beats.
  - DDR_addr = load counter; cache_in = s_axis_tdata.
  - The counter increments on each handshake.
  - On acceptance of beat CHUNK_CELLS-1: go to COMPUTE and assert lbm_start on the next cycle.
  - If tlast is seen on any other beat, or tlast is absent on the final beat, set load_err. Counting continues either way; tlast never ends LOAD early.
- COMPUTE:
  - chunk_compute_ready=1, chunk_transfer_ready=0.
  - lbm_done -> DRAIN.
  - If lbm_done arrives in the same cycle as lbm_start, it is honoured.
- DRAIN:
  - BRAM is READ_FIRST. cache_in=0, so the chunk is cleared as it is read.
  - A read is issued (chunk_transfer_ready=1, DDR_addr = read counter) when issue_cnt < CHUNK_CELLS and (occ - pop + inflight) < 2.
    - occ: skid buffer occupancy, 0..2.
    - pop: m_axis_tvalid & m_axis_tready.
    - inflight: 1 if a read was issued in the previous cycle.
  - cache_out is captured into the 2-entry skid buffer exactly one cycle after issue.
  - m_axis presents the skid buffer head.
  - m_axis_tlast=1 on beat CHUNK_CELLS-1.
  - With tready held high, throughput is 1 beat/cycle after a 2-cycle initial latency (issue, capture, present).
  - Once the last beat is accepted: chunk_done pulses, then IDLE.
- When not in LOAD or DRAIN: chunk_transfer_ready=0 and DDR_addr=0.
- chunk_transfer_ready and chunk_compute_ready are never high together.
- Counter widths: counters are $clog2(CHUNK_CELLS)+1 bits. The counter does not wrap; compare against CHUNK_CELLS.
- m_axis_tdata/tvalid/tlast are stable while tvalid & !tready (AXIS rule).

Test Plan:
- CHUNK_CELLS=8, DATA_W=16.
  1. Load beats with data i*0x1111 and tlast on beat 7 -> 8 writes at DDR_addr 0..7; lbm_start pulses one cycle after beat 7; load_err=0.
  2. Stream stalls: s_axis_tvalid toggles 1,0,1,0 -> chunk_transfer_ready mirrors tvalid; exactly 8 writes occur; addresses increment only on handshakes.
  3. tlast on beat 3 -> load_err=1 and stays 1; LOAD still completes after 8 beats.
  4. lbm_done one cycle after lbm_start, tready=1 -> 8 beats come out back-to-back; tdata equals the loaded values; tlast on beat 7; chunk_done pulses once; the BRAM model reads back 0 afterwards.
  5. m_axis_tready pattern 1,0,0,1,0,1... -> no beat lost or duplicated; tdata stable during stalls; inflight+occupancy never exceeds 2.
  6. Reset asserted in DRAIN at beat 4 -> next cycle all outputs are 0 and the state is IDLE; a new start runs a full chunk correctly.
